// File: rtl/hilo_seq.sv
// +----------------------------------------------------------------------------+
// | hilo_seq : multiply/divide sequencer and owner of architectural HI/LO      |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module hilo_seq #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_sel,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        unit_clr,
    output logic        mult_start,
    output logic        div_start,
    input  logic        mult_stop,
    input  logic        div_stop,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        err_div0,
    output logic        err_timeout
);

    localparam logic [7:0] C_TLAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLR   = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sel;
    logic [31:0] r_unit_a;
    logic [31:0] r_unit_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [7:0]  r_cnt;
    logic        r_done;
    logic        r_err_div0;
    logic        r_err_timeout;

    logic        w_accept;
    logic        w_div0;
    logic        w_capture;
    logic        w_timeout;
    logic        w_stop;
    logic        w_clr;
    logic        w_mult_start;
    logic        w_div_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_div0       = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_clr        = 1'b0;
        w_mult_start = 1'b0;
        w_div_start  = 1'b0;
        // Only the launched unit's flag matters; the other unit is ignored.
        w_stop       = r_sel ? div_stop : mult_stop;
        case (r_state)
            S_IDLE: begin
                if (op_valid) begin
                    if (op_sel && (op_b == 32'd0)) begin
                        w_div0 = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = S_CLR;
                    end
                end
            end
            S_CLR: begin
                w_clr  = 1'b1;
                w_next = S_START;
            end
            S_START: begin
                w_mult_start = ~r_sel;
                w_div_start  = r_sel;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                if (w_stop) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end else if (r_cnt == C_TLAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel         <= 1'b0;
            r_unit_a      <= 32'd0;
            r_unit_b      <= 32'd0;
            r_hi          <= 32'd0;
            r_lo          <= 32'd0;
            r_cnt         <= 8'd0;
            r_done        <= 1'b0;
            r_err_div0    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_done        <= w_capture;
            r_err_div0    <= w_div0;
            r_err_timeout <= w_timeout;
            if (w_accept) begin
                r_sel    <= op_sel;
                r_unit_a <= op_a;
                r_unit_b <= op_b;
            end
            if (r_state == S_IDLE) begin
                if (wr_hi) r_hi <= wr_data;
                if (wr_lo) r_lo <= wr_data;
            end
            if (w_capture) begin
                r_hi <= r_sel ? div_hi : mult_hi;
                r_lo <= r_sel ? div_lo : mult_lo;
            end
            if (r_state == S_START) begin
                r_cnt <= 8'd0;
            end else if ((r_state == S_WAIT) && !w_stop && !w_timeout) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign op_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign unit_a      = r_unit_a;
    assign unit_b      = r_unit_b;
    assign unit_clr    = w_clr;
    assign mult_start  = w_mult_start;
    assign div_start   = w_div_start;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign done        = r_done;
    assign err_div0    = r_err_div0;
    assign err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_hilo_seq.sv
// +----------------------------------------------------------------------------+
// | tb_hilo_seq : directed scoreboard bench for hilo_seq with unit stand-ins   |
// | Rev 1.0     : initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hilo_seq;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic        op_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ready;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        unit_clr;
    logic        mult_start;
    logic        div_start;
    logic        mult_stop;
    logic        div_stop;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        err_div0;
    logic        err_timeout;

    hilo_seq #(.TIMEOUT(40)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_sel(op_sel), .op_a(op_a), .op_b(op_b),
        .op_ready(op_ready),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .unit_a(unit_a), .unit_b(unit_b), .unit_clr(unit_clr),
        .mult_start(mult_start), .div_start(div_start),
        .mult_stop(mult_stop), .div_stop(div_stop),
        .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
        .hi(hi), .lo(lo), .busy(busy), .done(done),
        .err_div0(err_div0), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: signed product, stop rises after edge 35 of an op.
    logic [63:0] m_prod;
    logic        m_run;
    logic [7:0]  m_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_prod <= 64'd0; m_run <= 1'b0; m_cnt <= 8'd0; mult_stop <= 1'b0;
        end else if (unit_clr) begin
            m_run <= 1'b0; m_cnt <= 8'd0; mult_stop <= 1'b0;
        end else if (mult_start) begin
            m_prod <= $signed(unit_a) * $signed(unit_b);
            m_run  <= 1'b1; m_cnt <= 8'd0;
        end else if (m_run) begin
            m_cnt <= m_cnt + 8'd1;
            if (m_cnt == 8'd32) begin
                mult_stop <= 1'b1; m_run <= 1'b0;
            end
        end
    end
    assign mult_hi = m_prod[63:32];
    assign mult_lo = m_prod[31:0];

    // Divider stand-in: unsigned quotient/remainder; div_en=0 models a hung unit.
    logic        div_en;
    logic        d_run;
    logic [7:0]  d_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_hi <= 32'd0; div_lo <= 32'd0; d_run <= 1'b0; d_cnt <= 8'd0; div_stop <= 1'b0;
        end else if (unit_clr) begin
            d_run <= 1'b0; d_cnt <= 8'd0; div_stop <= 1'b0;
        end else if (div_start) begin
            div_hi <= unit_a % unit_b; div_lo <= unit_a / unit_b;
            d_run  <= 1'b1; d_cnt <= 8'd0;
        end else if (d_run) begin
            d_cnt <= d_cnt + 8'd1;
            if (d_cnt == 8'd9 && div_en) begin
                div_stop <= 1'b1; d_run <= 1'b0;
            end
        end
    end

    int n_clr = 0, n_ms = 0, n_ds = 0, n_busy = 0;
    always @(posedge clk) begin
        if (unit_clr)   n_clr  <= n_clr + 1;
        if (mult_start) n_ms   <= n_ms + 1;
        if (div_start)  n_ds   <= n_ds + 1;
        if (busy)       n_busy <= n_busy + 1;
    end

    typedef struct {
        logic [2:0]  flags;   // {err_timeout, err_div0, done}
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_hl(input logic wh, input logic wl, input logic [31:0] d);
        @(negedge clk);
        wr_hi = wh; wr_lo = wl; wr_data = d;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
    endtask

    // Returns in cycle 0->1 (just after the accept edge).
    task automatic launch_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] flags, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.flags = flags; e.hi = eh; e.lo = el;
        sb.push_back(e);
        @(negedge clk);
        op_valid = 1'b1; op_sel = sel; op_a = a; op_b = b;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic finish_op(input string tag, input int exp_cyc);
        int          n;
        logic [31:0] h0, l0;
        logic        hold;
        exp_t        e;
        h0 = hi; l0 = lo; hold = 1'b1; n = 0;
        while (!(done || err_div0 || err_timeout) && n < 300) begin
            if (hi !== h0 || lo !== l0) hold = 1'b0;
            @(negedge clk);
            n++;
        end
        if (exp_cyc >= 0) check({tag, "_cycle"}, 64'(n), 64'(exp_cyc));
        check({tag, "_hold"}, 64'(hold), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_flags"}, 64'({err_timeout, err_div0, done}), 64'(e.flags));
            check({tag, "_hi"}, 64'(hi), 64'(e.hi));
            check({tag, "_lo"}, 64'(lo), 64'(e.lo));
        end
        @(negedge clk);
        check({tag, "_pulse_end"}, 64'({err_timeout, err_div0, done}), 64'd0);
        check({tag, "_ready"}, 64'(op_ready), 64'd1);
    endtask

    int c0, m0, d0, b0;

    initial begin
        reset = 1'b0; op_valid = 1'b0; op_sel = 1'b0; op_a = 32'd0; op_b = 32'd0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = 32'd0; div_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(op_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_unit", {unit_a, unit_b}, 64'd0);
        check("rst_ctl", 64'({unit_clr, mult_start, div_start, done, err_div0, err_timeout}), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 7 x -3 with exact latency and launch pulse counts
        c0 = n_clr; m0 = n_ms; d0 = n_ds;
        launch_op(1'b0, 32'h7, 32'hFFFFFFFD, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFEB);
        finish_op("mul7x-3", 36);
        check("mul7_clr", 64'(n_clr - c0), 64'd1);
        check("mul7_mstart", 64'(n_ms - m0), 64'd1);
        check("mul7_dstart", 64'(n_ds - d0), 64'd0);

        // back-to-back mults; second relies on the clear of the stale stop
        launch_op(1'b0, 32'h00010000, 32'h00010000, 3'b001, 32'd1, 32'd0);
        finish_op("mul2p32", 36);
        launch_op(1'b0, 32'd5, 32'd6, 3'b001, 32'd0, 32'd30);
        finish_op("mul5x6", 36);

        // divide by zero screening
        write_hl(1'b1, 1'b0, 32'h0000AAAA);
        write_hl(1'b0, 1'b1, 32'h00005555);
        check("mthi_mtlo", {hi, lo}, {32'h0000AAAA, 32'h00005555});
        c0 = n_clr; m0 = n_ms; d0 = n_ds; b0 = n_busy;
        launch_op(1'b1, 32'd9, 32'd0, 3'b010, 32'h0000AAAA, 32'h00005555);
        finish_op("div0", 0);
        check("div0_busy", 64'(n_busy - b0), 64'd0);
        check("div0_starts", 64'((n_ms - m0) + (n_ds - d0) + (n_clr - c0)), 64'd0);

        // hung divider
        div_en = 1'b0;
        launch_op(1'b1, 32'd100, 32'd7, 3'b100, 32'h0000AAAA, 32'h00005555);
        finish_op("timeout", 42);
        check("timeout_busy", 64'(busy), 64'd0);

        // completing divide selects div results
        div_en = 1'b1;
        m0 = n_ms; d0 = n_ds;
        launch_op(1'b1, 32'd100, 32'd7, 3'b001, 32'd2, 32'd14);
        finish_op("div100_7", -1);
        check("div_mstart", 64'(n_ms - m0), 64'd0);
        check("div_dstart", 64'(n_ds - d0), 64'd1);

        // mthi+mtlo together, then ignored while busy
        write_hl(1'b1, 1'b1, 32'h12345678);
        check("mthilo_both", {hi, lo}, {32'h12345678, 32'h12345678});
        launch_op(1'b0, 32'hFFFFFFFF, 32'd2, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFE);
        repeat (10) @(negedge clk);
        check("wait_busy", 64'(busy), 64'd1);
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEADBEEF;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("wr_ignored", {hi, lo}, {32'h12345678, 32'h12345678});
        finish_op("mul-1x2", -1);

        // asynchronous reset at edge 20 of a mult
        launch_op(1'b0, 32'd7, 32'd7, 3'b001, 32'd0, 32'd49);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_ready", 64'(op_ready), 64'd1);
        check("arst_unit", {unit_a, unit_b}, 64'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        launch_op(1'b0, 32'd3, 32'd4, 3'b001, 32'd0, 32'd12);
        finish_op("mul3x4", 36);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
